// File: rtl/cpu_pkg.sv
// cpu_pkg: state encodings, condition codes, opcodes and the latched control bundle
// shared by the instruction decoder and the core sequencer.
package cpu_pkg;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_BRANCH = 3'd5,
        ST_FAULT  = 3'd7
    } state_e;

    localparam logic [3:0] CC_EQ = 4'h0;
    localparam logic [3:0] CC_NE = 4'h1;
    localparam logic [3:0] CC_CS = 4'h2;
    localparam logic [3:0] CC_CC = 4'h3;
    localparam logic [3:0] CC_MI = 4'h4;
    localparam logic [3:0] CC_PL = 4'h5;
    localparam logic [3:0] CC_VS = 4'h6;
    localparam logic [3:0] CC_VC = 4'h7;
    localparam logic [3:0] CC_HI = 4'h8;
    localparam logic [3:0] CC_LS = 4'h9;
    localparam logic [3:0] CC_GE = 4'hA;
    localparam logic [3:0] CC_LT = 4'hB;
    localparam logic [3:0] CC_GT = 4'hC;
    localparam logic [3:0] CC_LE = 4'hD;
    localparam logic [3:0] CC_AL = 4'hE;
    localparam logic [3:0] CC_NV = 4'hF;

    localparam logic [4:0] OP_ADD     = 5'h00;
    localparam logic [4:0] OP_SUB     = 5'h01;
    localparam logic [4:0] OP_AND     = 5'h02;
    localparam logic [4:0] OP_ORR     = 5'h03;
    localparam logic [4:0] OP_EOR     = 5'h04;
    localparam logic [4:0] OP_MOV     = 5'h05;
    localparam logic [4:0] OP_CMP     = 5'h06;
    localparam logic [4:0] OP_LDR     = 5'h07;
    localparam logic [4:0] OP_STR     = 5'h08;
    localparam logic [4:0] OP_B       = 5'h09;
    localparam logic [4:0] OP_BL      = 5'h0A;
    localparam logic [4:0] OP_INVALID = 5'h1F;

    typedef struct packed {
        logic reg_write;
        logic mem_read;
        logic mem_write;
        logic branch;
        logic link;
        logic flags_update;
    } ctrl_t;

    localparam ctrl_t CTRL_NONE = 6'b000000;

endpackage

// File: rtl/cond_check.sv
// cond_check: combinational ARM condition-code evaluation against {N,Z,C,V}.
module cond_check
    import cpu_pkg::*;
(
    input  logic [3:0] condition,
    input  logic [3:0] nzcv,
    output logic       pass
);
    logic n_s, z_s, c_s, v_s;

    assign {n_s, z_s, c_s, v_s} = nzcv;

    // Condition lookup; NV falls into the default and never passes
    always_comb begin
        pass = 1'b0;
        case (condition)
            CC_EQ:   pass = z_s;
            CC_NE:   pass = ~z_s;
            CC_CS:   pass = c_s;
            CC_CC:   pass = ~c_s;
            CC_MI:   pass = n_s;
            CC_PL:   pass = ~n_s;
            CC_VS:   pass = v_s;
            CC_VC:   pass = ~v_s;
            CC_HI:   pass = c_s & ~z_s;
            CC_LS:   pass = ~c_s | z_s;
            CC_GE:   pass = (n_s == v_s);
            CC_LT:   pass = (n_s != v_s);
            CC_GT:   pass = ~z_s & (n_s == v_s);
            CC_LE:   pass = z_s | (n_s != v_s);
            CC_AL:   pass = 1'b1;
            default: pass = 1'b0;
        endcase
    end
endmodule

// File: rtl/core_sequencer.sv
// core_sequencer: multi-cycle fetch/decode/exec/mem/writeback control FSM with Moore outputs.
// Define CORE_SEQ_PERF_EN to add the retired_cnt/stall_cnt performance counters.
module core_sequencer
    import cpu_pkg::*;
#(
    parameter int MEM_TIMEOUT  = 16,
    parameter int IMEM_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        imem_ready,
    input  logic        dmem_ready,
    input  logic [4:0]  opcode,
    input  logic [3:0]  condition,
    input  logic [3:0]  flags_nzcv,
    input  logic        reg_write_en,
    input  logic        mem_read_en,
    input  logic        mem_write_en,
    input  logic        branch_en,
    input  logic        link_en,
    input  logic        flags_update_en,
    output logic        imem_req,
    output logic        ir_load,
    output logic        alu_en,
    output logic        flags_we,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic        rf_we,
    output logic        lr_we,
    output logic        pc_inc,
    output logic        pc_branch,
    output logic        fault,
`ifdef CORE_SEQ_PERF_EN
    output logic [31:0] retired_cnt,
    output logic [31:0] stall_cnt,
`endif
    output logic [2:0]  state_o
);
    localparam logic [7:0] IMEM_LAST = 8'(IMEM_TIMEOUT - 1);
    localparam logic [7:0] MEM_LAST  = 8'(MEM_TIMEOUT - 1);

    state_e     state_q, state_d;
    logic [7:0] wait_q, wait_d;
    ctrl_t      ctrl_q, ctrl_d;
    logic       run_q, run_d;
    logic       inc_q, inc_d;
    logic       cond_pass_s;

    cond_check u_cond_check (
        .condition (condition),
        .nzcv      (flags_nzcv),
        .pass      (cond_pass_s)
    );

    // State, wait counter, latched controls; run_q holds off fetch for the first cycle after reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_FETCH;
            wait_q  <= 8'd0;
            ctrl_q  <= CTRL_NONE;
            run_q   <= 1'b0;
            inc_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            ctrl_q  <= ctrl_d;
            run_q   <= run_d;
            inc_q   <= inc_d;
        end
    end

    // Next-state logic; inc_d defers the PC increment into the first cycle of the next FETCH
    always_comb begin
        state_d = state_q;
        ctrl_d  = ctrl_q;
        run_d   = 1'b1;
        inc_d   = 1'b0;
        case (state_q)
            ST_FETCH: begin
                if (!run_q) begin
                    state_d = ST_FETCH;
                end else if (imem_ready) begin
                    state_d = ST_DECODE;
                end else if (wait_q == IMEM_LAST) begin
                    state_d = ST_FAULT;
                end else begin
                    state_d = ST_FETCH;
                end
            end
            ST_DECODE: begin
                ctrl_d.reg_write    = reg_write_en;
                ctrl_d.mem_read     = mem_read_en;
                ctrl_d.mem_write    = mem_write_en;
                ctrl_d.branch       = branch_en;
                ctrl_d.link         = link_en;
                ctrl_d.flags_update = flags_update_en;
                if (opcode == OP_INVALID) begin
                    state_d = ST_FAULT;
                end else if (!cond_pass_s) begin
                    state_d = ST_FETCH;
                    inc_d   = 1'b1;
                end else begin
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (ctrl_q.mem_read || ctrl_q.mem_write) begin
                    state_d = ST_MEM;
                end else if (ctrl_q.branch) begin
                    state_d = ST_BRANCH;
                end else if (ctrl_q.reg_write) begin
                    state_d = ST_WB;
                end else begin
                    state_d = ST_FETCH;
                    inc_d   = 1'b1;
                end
            end
            ST_MEM: begin
                if (dmem_ready) begin
                    if (ctrl_q.mem_write) begin
                        state_d = ST_FETCH;
                        inc_d   = 1'b1;
                    end else begin
                        state_d = ST_WB;
                    end
                end else if (wait_q == MEM_LAST) begin
                    state_d = ST_FAULT;
                end else begin
                    state_d = ST_MEM;
                end
            end
            ST_WB:     state_d = ST_FETCH;
            ST_BRANCH: state_d = ST_FETCH;
            ST_FAULT:  state_d = ST_FAULT;
            default:   state_d = ST_FAULT;
        endcase

        if (state_d != state_q) begin
            wait_d = 8'd0;
        end else if (!run_q || wait_q == 8'hFF) begin
            wait_d = wait_q;
        end else begin
            wait_d = wait_q + 8'd1;
        end
    end

    // Moore output decode from the state register and latched controls only
    always_comb begin
        imem_req  = 1'b0;
        ir_load   = 1'b0;
        alu_en    = 1'b0;
        flags_we  = 1'b0;
        dmem_req  = 1'b0;
        dmem_we   = 1'b0;
        rf_we     = 1'b0;
        lr_we     = 1'b0;
        pc_inc    = 1'b0;
        pc_branch = 1'b0;
        fault     = 1'b0;
        case (state_q)
            ST_FETCH: begin
                imem_req = run_q;
                pc_inc   = inc_q;
            end
            ST_DECODE: ir_load = 1'b1;
            ST_EXEC: begin
                alu_en   = 1'b1;
                flags_we = ctrl_q.flags_update;
            end
            ST_MEM: begin
                dmem_req = 1'b1;
                dmem_we  = ctrl_q.mem_write;
            end
            ST_WB: begin
                rf_we  = 1'b1;
                pc_inc = 1'b1;
            end
            ST_BRANCH: begin
                pc_branch = 1'b1;
                lr_we     = ctrl_q.link;
            end
            ST_FAULT: fault = 1'b1;
            default:  fault = 1'b0;
        endcase
    end

    assign state_o = state_q;

`ifdef CORE_SEQ_PERF_EN
    logic [31:0] retired_q, retired_d;
    logic [31:0] stall_q, stall_d;

    // Retire on every return to FETCH; stall on each requesting cycle without ready
    always_comb begin
        if (state_d == ST_FETCH && state_q != ST_FETCH && state_q != ST_FAULT) begin
            retired_d = retired_q + 32'd1;
        end else begin
            retired_d = retired_q;
        end
        if ((state_q == ST_FETCH && run_q && !imem_ready) ||
            (state_q == ST_MEM && !dmem_ready)) begin
            stall_d = stall_q + 32'd1;
        end else begin
            stall_d = stall_q;
        end
    end

    // Performance counter registers, wrapping
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            retired_q <= 32'd0;
            stall_q   <= 32'd0;
        end else begin
            retired_q <= retired_d;
            stall_q   <= stall_d;
        end
    end

    assign retired_cnt = retired_q;
    assign stall_cnt   = stall_q;
`endif

endmodule

// File: doc/core_sequencer.md
Name: core_sequencer

Overview:
Multi-cycle control FSM that sequences one instruction at a time through fetch, decode, execute, memory and writeback. It consumes the control bundle produced by the instruction decoder and drives the enables for the PC, IR, ALU, flags, register file and data memory. It evaluates ARM condition codes against NZCV and raises a sticky fault on invalid opcodes or memory timeouts.

Parameters:
MEM_TIMEOUT, 16, max cycles dmem_req may wait for dmem_ready before FAULT; legal range 1..255.
IMEM_TIMEOUT, 16, max cycles imem_req may wait for imem_ready before FAULT; legal range 1..255.

Ports:
clk  in  1  core clock
rst_n  in  1  asynchronous active-low reset
imem_ready  in  1  instruction word valid this cycle
dmem_ready  in  1  data access complete this cycle
opcode  in  5  decoder opcode; 5'h1F = invalid
condition  in  4  decoder condition field
flags_nzcv  in  4  current flags {N,Z,C,V}
reg_write_en, mem_read_en, mem_write_en, branch_en, link_en, flags_update_en  in  1 each  decoder controls
imem_req  out  1  instruction fetch request
ir_load  out  1  latch instruction register
alu_en  out  1  ALU operation strobe
flags_we  out  1  flag register write
dmem_req  out  1  data memory request
dmem_we  out  1  data memory write (valid with dmem_req)
rf_we  out  1  register file write
lr_we  out  1  write return address to r14
pc_inc  out  1  PC <= PC+4
pc_branch  out  1  PC <= branch target
fault  out  1  sticky fault indicator
state_o  out  3  current state encoding (debug)

Behaviour:
- State encodings: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, BRANCH=5, FAULT=7. Outputs are Moore, decoded from the state register and the latched controls. There is no combinational path from decoder inputs to outputs.
- Reset (rst_n low, asynchronous): state=FETCH, wait counter=0, latched controls=0, all outputs 0. imem_req rises in the first cycle after release.
- FETCH: imem_req=1 each cycle until imem_ready.
  - imem_ready: ir_load=1 in the next state (DECODE, first cycle).
  - IMEM_TIMEOUT cycles without imem_ready: go to FAULT.
- DECODE (1 cycle): latch the decoder controls and evaluate the condition against flags_nzcv.
  - Condition table (ARM standard): EQ, NE, CS, CC, MI, PL, VS, VC, HI, LS, GE, LT, GT, LE, AL=1110. NV=1111 always fails.
  - opcode==5'h1F (checked first): go to FAULT.
  - Condition fails: pc_inc for one cycle, then FETCH.
  - Otherwise: go to EXEC.
- EXEC (1 cycle): alu_en=1; flags_we=flags_update_en. Next state by priority:
  - mem_read_en or mem_write_en: MEM.
  - branch_en: BRANCH.
  - reg_write_en: WB.
  - none of these: pc_inc, then FETCH.
- MEM: dmem_req=1 and dmem_we=mem_write_en, held until dmem_ready.
  - On dmem_ready: a load goes to WB; a store asserts pc_inc and goes to FETCH.
  - MEM_TIMEOUT waiting cycles: go to FAULT with dmem_req deasserted.
- WB (1 cycle): rf_we=1, pc_inc=1, then FETCH.
- BRANCH (1 cycle): pc_branch=1; lr_we=link_en. pc_inc is not asserted. Then FETCH.
- FAULT: absorbing state. fault=1 and every other output is 0 until rst_n.
- Wait counter: 8-bit, cleared on each state entry, saturates.
- Exclusivity: at most one of pc_inc and pc_branch is asserted in any cycle.
- Decoder inputs are ignored outside DECODE.
- Reset mid-MEM drops dmem_req immediately (asynchronously).
- Nominal latencies (ready=1 on first cycle):
  - ALU with writeback: 4 cycles.
  - Load: 5 cycles.
  - Store: 4 cycles.
  - Branch: 4 cycles.
  - Condition-failed: 2 cycles.

Optional Feature:
CORE_SEQ_PERF_EN:
- Defined: adds outputs retired_cnt[31:0] and stall_cnt[31:0].
  - retired_cnt increments on each FETCH entry that follows a completed instruction, including condition-failed instructions.
  - stall_cnt increments on each FETCH or MEM cycle in which ready is low.
  - Both counters wrap and reset to 0.
- Undefined: the ports and logic are absent.

Decomposition:
- Shared package (cpu_pkg):
  - State encodings.
  - Condition-code constants.
  - OP_INVALID=5'h1F.
  - OP_* opcode defines, shared with the decoder.
- Sub-module cond_check: combinational; condition[3:0] and nzcv[3:0] in, pass out. Instantiated once.

Test Plan:
- ADD r2,r1,r3 (AL, reg_write_en=1), both ready signals tied high -> exactly one pulse each of ir_load, alu_en, rf_we, pc_inc; back in FETCH 4 cycles after reset release.
- LDR with dmem_ready delayed 3 cycles -> dmem_req high 4 cycles, dmem_we=0, then rf_we=1 and pc_inc=1 in the same cycle; stall_cnt=3 when CORE_SEQ_PERF_EN is defined.
- BEQ with flags 4'b0100 (Z=1) -> pc_branch=1, pc_inc=0, lr_we=0. The same instruction with flags 4'b0000 -> pc_inc=1, no alu_en.
- BL (AL, link_en=1) -> pc_branch=1 and lr_we=1 in the same cycle; rf_we=0.
- opcode=5'h1F -> fault=1 from the cycle after DECODE and all other outputs 0 for 20 cycles. Asserting rst_n low then returns to FETCH with fault=0.
- STR with dmem_ready stuck low, MEM_TIMEOUT=4 -> FAULT after 4 MEM cycles; rf_we and pc_inc are never asserted.
